// File: rtl/logic_74hc_pkg.sv
// Shared constants and types for the 74HC193 counter emulation.
// LOGIC_74HC193_SYNC_STAGES is the synchronizer depth used when LOGIC_74HC193_INPUT_SYNC_EN is set.
package logic_74hc_pkg;

  localparam int unsigned LOGIC_74HC193_SYNC_STAGES = 2;

  typedef enum logic [1:0] {
    CntHold,
    CntUp,
    CntDown,
    CntLoad
  } cntAction_t;

  // All-ones value of a counter of the given width.
  function automatic int unsigned maxCount(int unsigned width);
    return (32'd1 << width) - 32'd1;
  endfunction

endpackage

// File: rtl/logic_74hc193_sync_if.sv
// Counter data/strobe bundle: load, strobes and data in, count and terminal-count flags out.
interface logic_74hc193_sync_if #(
  parameter int unsigned WIDTH = 4
);
  logic             nPL;
  logic             CPU;
  logic             CPD;
  logic [WIDTH-1:0] D;
  logic [WIDTH-1:0] Q;
  logic             nTCU;
  logic             nTCD;

  modport master (output nPL, CPU, CPD, D, input Q, nTCU, nTCD);
  modport slave  (input nPL, CPU, CPD, D, output Q, nTCU, nTCD);
endinterface

// File: rtl/logic_sync_edge.sv
// Per-strobe optional synchronizer (LOGIC_74HC193_INPUT_SYNC_EN) plus rising-edge detector.
module logic_sync_edge
  import logic_74hc_pkg::*;
(
  input  logic CP,
  input  logic nMR,
  input  logic din,
  output logic sampled,
  output logic rise
);

`ifdef LOGIC_74HC193_INPUT_SYNC_EN
  logic [LOGIC_74HC193_SYNC_STAGES-1:0] syncQ;

  always_ff @(posedge CP) begin
    if (!nMR) begin
      syncQ <= '1;
    end else begin
      syncQ <= {syncQ[LOGIC_74HC193_SYNC_STAGES-2:0], din};
    end
  end

  assign sampled = syncQ[LOGIC_74HC193_SYNC_STAGES-1];
`else
  assign sampled = din;
`endif

  logic prevQ;

  // Idle-high history so a strobe already high at reset release does not count.
  always_ff @(posedge CP) begin
    if (!nMR) begin
      prevQ <= 1'b1;
    end else begin
      prevQ <= sampled;
    end
  end

  assign rise = sampled & ~prevQ;

endmodule

// File: rtl/logic_74hc193_sync.sv
// Synchronous 74HC193 up/down counter with parallel load and cascadable terminal counts.
// Define LOGIC_74HC193_INPUT_SYNC_EN to synchronize CPU, CPD and nPL for asynchronous sources.
module logic_74hc193_sync
  import logic_74hc_pkg::*;
#(
  parameter int unsigned WIDTH = 4
) (
  input logic                CP,
  input logic                nMR,
  logic_74hc193_sync_if.slave bus
);

  localparam logic [WIDTH-1:0] MaxQ = WIDTH'(maxCount(WIDTH));

  logic cpuS, cpdS, upEvt, dnEvt, nplS;

  logic_sync_edge uCpuEdge (
    .CP     (CP),
    .nMR    (nMR),
    .din    (bus.CPU),
    .sampled(cpuS),
    .rise   (upEvt)
  );

  logic_sync_edge uCpdEdge (
    .CP     (CP),
    .nMR    (nMR),
    .din    (bus.CPD),
    .sampled(cpdS),
    .rise   (dnEvt)
  );

`ifdef LOGIC_74HC193_INPUT_SYNC_EN
  logic [LOGIC_74HC193_SYNC_STAGES-1:0] nplSyncQ;

  always_ff @(posedge CP) begin
    if (!nMR) begin
      nplSyncQ <= '1;
    end else begin
      nplSyncQ <= {nplSyncQ[LOGIC_74HC193_SYNC_STAGES-2:0], bus.nPL};
    end
  end

  assign nplS = nplSyncQ[LOGIC_74HC193_SYNC_STAGES-1];
`else
  assign nplS = bus.nPL;
`endif

  cntAction_t       action;
  logic [WIDTH-1:0] cntQ, cntD;

  // Load wins over counting; coincident up and down edges cancel.
  always_comb begin
    action = CntHold;
    if (!nplS) begin
      action = CntLoad;
    end else if (upEvt && !dnEvt) begin
      action = CntUp;
    end else if (dnEvt && !upEvt) begin
      action = CntDown;
    end
  end

  always_comb begin
    cntD = cntQ;
    unique case (action)
      CntLoad: cntD = bus.D;
      CntUp:   cntD = cntQ + 1'b1;
      CntDown: cntD = cntQ - 1'b1;
      default: cntD = cntQ;
    endcase
  end

  always_ff @(posedge CP) begin
    if (!nMR) begin
      cntQ <= '0;
    end else begin
      cntQ <= cntD;
    end
  end

  assign bus.Q    = cntQ;
  assign bus.nTCU = ~((cntQ == MaxQ) & ~cpuS);
  assign bus.nTCD = ~((cntQ == '0) & ~cpdS);

endmodule

// File: tb/tb_logic_74hc193_sync.sv
// Randomized and directed bench for logic_74hc193_sync against a strobe-history reference model.
// Honours LOGIC_74HC193_INPUT_SYNC_EN by shifting the model's sampling point by two cycles.
module tb_logic_74hc193_sync;

`ifdef LOGIC_74HC193_INPUT_SYNC_EN
  localparam int Lat = 2;
`else
  localparam int Lat = 0;
`endif

  logic CP  = 1'b0;
  logic nMR = 1'b0;

  always #5 CP = ~CP;

  logic_74hc193_sync_if #(.WIDTH(4)) lo ();
  logic_74hc193_sync_if #(.WIDTH(4)) hi ();

  assign hi.CPU = lo.nTCU;
  assign hi.CPD = lo.nTCD;

  logic_74hc193_sync #(.WIDTH(4)) dutLo (.CP(CP), .nMR(nMR), .bus(lo));
  logic_74hc193_sync #(.WIDTH(4)) dutHi (.CP(CP), .nMR(nMR), .bus(hi));

  int vectors     = 0;
  int miscompares = 0;

  // Reference: history of strobe/load levels seen at each edge, plus the count.
  bit         hCpu[$];
  bit         hCpd[$];
  bit         hNpl[$];
  logic [3:0] mQ;

  function automatic void modelReset();
    hCpu.delete(); hCpd.delete(); hNpl.delete();
    for (int i = 0; i < 4; i++) begin
      hCpu.push_back(1'b1); hCpd.push_back(1'b1); hNpl.push_back(1'b1);
    end
    mQ = 4'h0;
  endfunction

  function automatic void modelEdge();
    int n;
    bit upE, dnE;
    if (!nMR) begin
      modelReset();
      return;
    end
    hCpu.push_back(lo.CPU); hCpd.push_back(lo.CPD); hNpl.push_back(lo.nPL);
    n   = hCpu.size();
    upE = hCpu[n-1-Lat] && !hCpu[n-2-Lat];
    dnE = hCpd[n-1-Lat] && !hCpd[n-2-Lat];
    if (!hNpl[n-1-Lat]) mQ = lo.D;
    else if (upE && !dnE) mQ = mQ + 4'd1;
    else if (dnE && !upE) mQ = mQ - 4'd1;
    if (hCpu.size() > 6) begin
      void'(hCpu.pop_front()); void'(hCpd.pop_front()); void'(hNpl.pop_front());
    end
  endfunction

  // Expected {nTCU, nTCD} after the most recent edge.
  function automatic logic [1:0] expTc();
    bit cs, ds;
`ifdef LOGIC_74HC193_INPUT_SYNC_EN
    cs = hCpu[hCpu.size()-2];
    ds = hCpd[hCpd.size()-2];
`else
    cs = lo.CPU;
    ds = lo.CPD;
`endif
    return {!(mQ == 4'hF && !cs), !(mQ == 4'h0 && !ds)};
  endfunction

  task automatic step(input bit cpu, input bit cpd, input bit npl, input bit mr,
                      input logic [3:0] d);
    @(negedge CP);
    lo.CPU = cpu; lo.CPD = cpd; lo.nPL = npl; lo.D = d; nMR = mr;
    @(posedge CP);
    modelEdge();
    #1;
  endtask

  task automatic test_reset();
    for (int i = 0; i < 5; i++) begin
      step(1'b1, 1'b1, 1'b1, (i >= 2), 4'h9);
      if (lo.Q !== 4'h0 || {lo.nTCU, lo.nTCD} !== 2'b11) begin
        miscompares++;
        $display("FAIL reset step %0d: Q=%h tc=%b want Q=0 tc=11", i, lo.Q, {lo.nTCU, lo.nTCD});
      end
      vectors++;
    end
  endtask

  task automatic test_load_count_up();
    bit sawTcu = 0;
    for (int i = 0; i < 11; i++) begin
      step(!(i == 4 || i == 6), 1'b1, (i != 0), 1'b1, 4'hE);
      if (lo.Q !== mQ || {lo.nTCU, lo.nTCD} !== expTc()) begin
        miscompares++;
        $display("FAIL load_up step %0d: Q=%h tc=%b want Q=%h tc=%b",
                 i, lo.Q, {lo.nTCU, lo.nTCD}, mQ, expTc());
      end
      vectors++;
      if (!lo.nTCU) sawTcu = 1;
    end
    if (lo.Q !== 4'h0 || !sawTcu) begin
      miscompares++;
      $display("FAIL load_up end: Q=%h sawTcuLow=%0d want Q=0 sawTcuLow=1", lo.Q, sawTcu);
    end
    vectors++;
  endtask

  task automatic test_down_borrow();
    bit sawTcd = 0;
    for (int i = 0; i < 11; i++) begin
      step(1'b1, !(i == 4 || i == 6), (i != 0), 1'b1, 4'h1);
      if (lo.Q !== mQ || {lo.nTCU, lo.nTCD} !== expTc()) begin
        miscompares++;
        $display("FAIL down_borrow step %0d: Q=%h tc=%b want Q=%h tc=%b",
                 i, lo.Q, {lo.nTCU, lo.nTCD}, mQ, expTc());
      end
      vectors++;
      if (!lo.nTCD) sawTcd = 1;
    end
    if (lo.Q !== 4'hF || !sawTcd) begin
      miscompares++;
      $display("FAIL down_borrow end: Q=%h sawTcdLow=%0d want Q=f sawTcdLow=1", lo.Q, sawTcd);
    end
    vectors++;
  endtask

  task automatic test_simultaneous();
    for (int i = 0; i < 14; i++) begin
      step(!(i == 4 || i == 9), !(i == 4), (i != 0), 1'b1, 4'h5);
      if (lo.Q !== mQ) begin
        miscompares++;
        $display("FAIL simultaneous step %0d: Q=%h want %h", i, lo.Q, mQ);
      end
      vectors++;
      if (i == 8 && lo.Q !== 4'h5) begin
        miscompares++;
        $display("FAIL simultaneous hold: Q=%h want 5", lo.Q);
      end
      if (i == 8) vectors++;
    end
    if (lo.Q !== 4'h6) begin
      miscompares++;
      $display("FAIL simultaneous then up: Q=%h want 6", lo.Q);
    end
    vectors++;
  endtask

  task automatic test_load_priority();
    for (int i = 0; i < 10; i++) begin
      step((i >= 6) || (i % 2 == 1), 1'b1, (i >= 6), 1'b1, 4'h3);
      if (lo.Q !== mQ) begin
        miscompares++;
        $display("FAIL load_priority step %0d: Q=%h want %h", i, lo.Q, mQ);
      end
      vectors++;
    end
    if (lo.Q !== 4'h3) begin
      miscompares++;
      $display("FAIL load_priority end: Q=%h want 3", lo.Q);
    end
    vectors++;
  endtask

  task automatic test_random();
    for (int i = 0; i < 400; i++) begin
      step(($urandom_range(2) != 0), ($urandom_range(2) != 0), ($urandom_range(9) != 0),
           ($urandom_range(39) != 0), 4'($urandom_range(15)));
      if (lo.Q !== mQ || {lo.nTCU, lo.nTCD} !== expTc()) begin
        miscompares++;
        $display("FAIL random step %0d: Q=%h tc=%b want Q=%h tc=%b",
                 i, lo.Q, {lo.nTCU, lo.nTCD}, mQ, expTc());
      end
      vectors++;
    end
  endtask

  // Runs last: it drives the DUTs without keeping the reference model in step.
  task automatic test_cascade();
    int loLat = 0;
    int hiLat = 0;
    @(negedge CP);
    nMR = 1'b0; lo.CPU = 1'b1; lo.CPD = 1'b1; lo.nPL = 1'b1; hi.nPL = 1'b1;
    repeat (2) @(negedge CP);
    nMR = 1'b1; lo.nPL = 1'b0; lo.D = 4'hF; hi.nPL = 1'b0; hi.D = 4'h0;
    @(negedge CP);
    lo.nPL = 1'b1; hi.nPL = 1'b1;
    repeat (4) @(negedge CP);
    if (lo.Q !== 4'hF || hi.Q !== 4'h0) begin
      miscompares++;
      $display("FAIL cascade preload: lo=%h hi=%h want lo=f hi=0", lo.Q, hi.Q);
    end
    vectors++;
    lo.CPU = 1'b0;
    @(negedge CP);
    lo.CPU = 1'b1;
    for (int k = 1; k <= 10; k++) begin
      @(posedge CP);
      #1;
      if (loLat == 0 && lo.Q == 4'h0) loLat = k;
      if (hiLat == 0 && hi.Q == 4'h1) hiLat = k;
    end
    if (loLat != 1 + Lat || hiLat != 1 + 2 * Lat) begin
      miscompares++;
      $display("FAIL cascade latency: lo=%0d hi=%0d cycles want lo=%0d hi=%0d",
               loLat, hiLat, 1 + Lat, 1 + 2 * Lat);
    end
    vectors++;
    if (lo.Q !== 4'h0 || hi.Q !== 4'h1) begin
      miscompares++;
      $display("FAIL cascade final: lo=%h hi=%h want lo=0 hi=1", lo.Q, hi.Q);
    end
    vectors++;
  endtask

  initial begin
    lo.CPU = 1'b1; lo.CPD = 1'b1; lo.nPL = 1'b1; lo.D = 4'h0;
    hi.nPL = 1'b1; hi.D = 4'h0;
    modelReset();
    test_reset();
    test_load_count_up();
    test_down_borrow();
    test_simultaneous();
    test_load_priority();
    test_random();
    test_cascade();
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
